pz_frame_buffer: RTL and testbench

- Upstream stage of pz_accumulator.
- Collects a stream of signed 16-bit pz samples into a frame of REG_FILE_SIZE entries.
- Commits each complete frame atomically onto flat_pz, which pz_accumulator sums.
- Double-buffered: a shadow bank fills while the output bank stays stable.
- Downstream hold freezes the output; hold back-pressures the producer once a complete frame is waiting.

---
 rtl/pz_pkg.sv | 8 +
 rtl/pz_frame_buffer.sv | 68 ++++++
 tb/tb_pz_frame_buffer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pz_pkg.sv
// pz_pkg: shared widths, state encoding and zero-fill helper for the pz frame pipeline
package pz_pkg;
    localparam int PZ_W = 16;
    typedef enum logic {PZ_FILL, PZ_PENDING} pz_state_t;
    function automatic logic [PZ_W-1:0] zero_fill(input logic [PZ_W-1:0] v, input int idx, input int last);
        return idx <= last ? v : '0;
    endfunction
endpackage

// File: rtl/pz_frame_buffer.sv
// pz_frame_buffer: collects pz samples into a shadow bank and commits whole frames onto flat_pz
module pz_frame_buffer
    import pz_pkg::*;
#(
    parameter int REG_FILE_SIZE = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PZ_W-1:0]               in_data,
    input  logic                          in_last,
    input  logic                          flush,
    input  logic                          hold,
    output logic [PZ_W*REG_FILE_SIZE-1:0] flat_pz,
    output logic                          frame_valid,
    output logic [15:0]                   frame_count
);
    localparam int PTR_W = REG_FILE_SIZE > 1 ? $clog2(REG_FILE_SIZE) : 1;
    logic [PZ_W-1:0] shadow [REG_FILE_SIZE];
    logic [PZ_W-1:0] merged [REG_FILE_SIZE];
    logic [PTR_W-1:0] wr_ptr;
    pz_state_t state;
    logic accept, complete;
    assign in_ready = state == PZ_FILL && !rst;
    assign accept = in_valid && in_ready;
    assign complete = accept && (int'(wr_ptr) == REG_FILE_SIZE - 1 || in_last);
    // the accepted sample lands in the frame on the same edge it completes it
    always_comb
        for (int i = 0; i < REG_FILE_SIZE; i++)
            merged[i] = zero_fill(accept && int'(wr_ptr) == i ? in_data : shadow[i], i, int'(wr_ptr));
    always_ff @(posedge clk) begin
        if (rst) begin
            flat_pz <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
            wr_ptr <= '0;
            state <= PZ_FILL;
            for (int i = 0; i < REG_FILE_SIZE; i++) shadow[i] <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (flush) begin
                wr_ptr <= '0;
                state <= PZ_FILL;
                for (int i = 0; i < REG_FILE_SIZE; i++) shadow[i] <= '0;
            end else if (state == PZ_PENDING) begin
                if (!hold) begin
                    for (int i = 0; i < REG_FILE_SIZE; i++) flat_pz[PZ_W*i +: PZ_W] <= shadow[i];
                    frame_count <= frame_count + 16'd1;
                    frame_valid <= 1'b1;
                    state <= PZ_FILL;
                end
            end else if (complete) begin
                wr_ptr <= '0;
                for (int i = 0; i < REG_FILE_SIZE; i++) shadow[i] <= merged[i];
                if (hold) state <= PZ_PENDING;
                else begin
                    for (int i = 0; i < REG_FILE_SIZE; i++) flat_pz[PZ_W*i +: PZ_W] <= merged[i];
                    frame_count <= frame_count + 16'd1;
                    frame_valid <= 1'b1;
                end
            end else if (accept) begin
                shadow[wr_ptr] <= in_data;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pz_frame_buffer.sv
// tb_pz_frame_buffer: directed checks of commit, early last, hold, flush, reset and counter wrap
module tb_pz_frame_buffer;
    logic clk = 1'b0;
    logic rst, flush, hold;
    logic v2, l2, v4, l4;
    logic [15:0] d2, d4;
    logic r2, r4, fv2, fv4;
    logic [31:0] flat2;
    logic [63:0] flat4;
    logic [15:0] cnt2, cnt4;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pz_frame_buffer #(.REG_FILE_SIZE(2)) dut (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(d2), .in_last(l2),
        .flush(flush), .hold(hold), .flat_pz(flat2), .frame_valid(fv2), .frame_count(cnt2)
    );
    pz_frame_buffer #(.REG_FILE_SIZE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_data(d4), .in_last(l4),
        .flush(flush), .hold(hold), .flat_pz(flat4), .frame_valid(fv4), .frame_count(cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send2(input logic [15:0] d);
        v2 = 1'b1; d2 = d;
        tick();
        v2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        v2 = 1'b0; l2 = 1'b0; d2 = '0; v4 = 1'b0; l4 = 1'b0; d4 = '0;
        tick(); tick();
        chk("rst_ready", 64'(r2), 64'd0);
        chk("rst_flat", 64'(flat2), 64'd0);
        chk("rst_fv", 64'(fv2), 64'd0);
        chk("rst_cnt", 64'(cnt2), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(r2), 64'd1);
        // basic commit
        send2(16'h0003);
        chk("no_pulse_mid", 64'(fv2), 64'd0);
        send2(16'hFFFF);
        chk("basic_flat", 64'(flat2), 64'hFFFF_0003);
        chk("basic_fv", 64'(fv2), 64'd1);
        chk("basic_cnt", 64'(cnt2), 64'd1);
        tick();
        chk("pulse_one_cycle", 64'(fv2), 64'd0);
        // early in_last on N=4
        v4 = 1'b1; d4 = 16'h0010; l4 = 1'b1;
        tick();
        l4 = 1'b0;
        chk("early_flat", flat4, 64'h0000_0000_0000_0010);
        chk("early_fv", 64'(fv4), 64'd1);
        chk("early_cnt", 64'(cnt4), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            d4 = 16'(i);
            tick();
        end
        v4 = 1'b0;
        chk("after_early_flat", flat4, 64'h0004_0003_0002_0001);
        chk("after_early_cnt", 64'(cnt4), 64'd2);
        // hold back-pressure
        hold = 1'b1;
        send2(16'd5);
        chk("hold_fill_ready", 64'(r2), 64'd1);
        send2(16'd7);
        chk("pend_ready", 64'(r2), 64'd0);
        chk("pend_flat", 64'(flat2), 64'hFFFF_0003);
        chk("pend_fv", 64'(fv2), 64'd0);
        v2 = 1'b1; d2 = 16'h0BAD;
        tick();
        v2 = 1'b0;
        chk("pend_stable", 64'(flat2), 64'hFFFF_0003);
        chk("pend_cnt", 64'(cnt2), 64'd1);
        hold = 1'b0;
        tick();
        chk("release_flat", 64'(flat2), 64'h0007_0005);
        chk("release_fv", 64'(fv2), 64'd1);
        chk("release_cnt", 64'(cnt2), 64'd2);
        chk("release_ready", 64'(r2), 64'd1);
        // flush mid-frame discards the sample accepted on the flush edge
        send2(16'd9);
        flush = 1'b1;
        send2(16'd4);
        flush = 1'b0;
        chk("flush_flat", 64'(flat2), 64'h0007_0005);
        chk("flush_fv", 64'(fv2), 64'd0);
        send2(16'd1);
        chk("flush_nocommit", 64'(cnt2), 64'd2);
        send2(16'd2);
        chk("post_flush_flat", 64'(flat2), 64'h0002_0001);
        chk("post_flush_cnt", 64'(cnt2), 64'd3);
        // flush while pending
        hold = 1'b1;
        send2(16'h000A);
        send2(16'h000B);
        chk("pend2_ready", 64'(r2), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("pflush_ready", 64'(r2), 64'd1);
        chk("pflush_flat", 64'(flat2), 64'h0002_0001);
        chk("pflush_cnt", 64'(cnt2), 64'd3);
        hold = 1'b0;
        tick();
        chk("pflush_dropped_fv", 64'(fv2), 64'd0);
        chk("pflush_dropped_flat", 64'(flat2), 64'h0002_0001);
        send2(16'h000C);
        send2(16'h000D);
        chk("pflush_next_flat", 64'(flat2), 64'h000D_000C);
        chk("pflush_next_cnt", 64'(cnt2), 64'd4);
        // reset mid-frame
        send2(16'h0055);
        rst = 1'b1;
        tick();
        chk("mrst_flat", 64'(flat2), 64'd0);
        chk("mrst_cnt", 64'(cnt2), 64'd0);
        chk("mrst_ready", 64'(r2), 64'd0);
        chk("mrst_flat4", flat4, 64'd0);
        rst = 1'b0;
        send2(16'd6);
        send2(16'd8);
        chk("mrst_next_flat", 64'(flat2), 64'h0008_0006);
        chk("mrst_next_cnt", 64'(cnt2), 64'd1);
        // frame_count wrap
        force dut.frame_count = 16'hFFFF;
        tick();
        release dut.frame_count;
        tick();
        chk("wrap_pre", 64'(cnt2), 64'hFFFF);
        send2(16'd1);
        send2(16'd2);
        chk("wrap_cnt", 64'(cnt2), 64'd0);
        chk("wrap_fv", 64'(fv2), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
